// File: rtl/sram_pkg.sv
// Shared definitions for the Wishbone-to-asynchronous-SRAM controller:
// FSM state encoding, wait-counter width and data/select width helpers.
package sram_pkg;

  localparam int CNT_W     = 4;
  localparam int DEF_CHIPS = 2;
  localparam int DEF_DW    = 16 * DEF_CHIPS;
  localparam int DEF_SW    = 2 * DEF_CHIPS;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ACC   = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    ACK      = 3'd5,
    TURN     = 3'd6
  } sram_state_e;

  function automatic int data_w(input int chips);
    return 16 * chips;
  endfunction

  function automatic int sel_w(input int chips);
    return 2 * chips;
  endfunction

endpackage

// File: rtl/sram_lane_map.sv
// Byte-select to per-device chip/byte enable decode (active low, combinational).
// The parent registers these values before they reach the pins.
module sram_lane_map #(
  parameter int CHIPS = 2
) (
  input  logic [2*CHIPS-1:0] sel,
  output logic [CHIPS-1:0]   cen,
  output logic [CHIPS-1:0]   ubn,
  output logic [CHIPS-1:0]   lbn
);

  // a device is enabled only when at least one of its two byte lanes is selected
  always_comb begin
    cen = {CHIPS{1'b1}};
    ubn = {CHIPS{1'b1}};
    lbn = {CHIPS{1'b1}};
    for (int c = 0; c < CHIPS; c++) begin
      cen[c] = ~(sel[2*c+1] | sel[2*c]);
      ubn[c] = ~sel[2*c+1];
      lbn[c] = ~sel[2*c];
    end
  end

endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave driving CHIPS parallel 16-bit asynchronous SRAMs with
// registered pin timing, programmable wait states, write setup/hold and abort handling.
module wb_sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int CHIPS   = 2,
  parameter int WAIT_RD = 1,
  parameter int WAIT_WR = 2,
  localparam int DW     = data_w(CHIPS),
  localparam int SW     = sel_w(CHIPS)
) (
  input  logic              clk_50mhz,
  input  logic              reset,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [SW-1:0]     wb_sel_i,
  input  logic [DW-1:0]     wb_dat_i,
  output logic [DW-1:0]     wb_dat_o,
  output logic              wb_ack_o,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DW-1:0]     sram_dq_i,
  output logic [DW-1:0]     sram_dq_o,
  output logic [SW-1:0]     sram_dq_oe,
  output logic [CHIPS-1:0]  sram_cen,
  output logic [CHIPS-1:0]  sram_ubn,
  output logic [CHIPS-1:0]  sram_lbn,
  output logic              sram_oen,
  output logic              sram_wen
);

  sram_state_e       state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [SW-1:0]     sel_r, sel_s;
  logic              ack_r, ack_s;
  logic [DW-1:0]     dat_r, dat_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DW-1:0]     dq_o_r, dq_o_s;
  logic [SW-1:0]     dq_oe_r, dq_oe_s;
  logic [CHIPS-1:0]  cen_r, cen_s, ubn_r, ubn_s, lbn_r, lbn_s;
  logic              oen_r, oen_s, wen_r, wen_s;
  logic [CHIPS-1:0]  lane_cen_s, lane_ubn_s, lane_lbn_s;

  function automatic logic [DW-1:0] byte_mask(input logic [SW-1:0] s);
    logic [DW-1:0] m;
    m = {DW{1'b0}};
    for (int k = 0; k < SW; k++) begin
      m[8*k +: 8] = {8{s[k]}};
    end
    return m;
  endfunction

  sram_lane_map #(.CHIPS(CHIPS)) u_lane_map (
    .sel (wb_sel_i),
    .cen (lane_cen_s),
    .ubn (lane_ubn_s),
    .lbn (lane_lbn_s)
  );

  // next-state and next pin values; every pin is registered on entry to its state
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    sel_s   = sel_r;
    ack_s   = 1'b0;
    dat_s   = dat_r;
    addr_s  = addr_r;
    dq_o_s  = dq_o_r;
    dq_oe_s = dq_oe_r;
    cen_s   = cen_r;
    ubn_s   = ubn_r;
    lbn_s   = lbn_r;
    oen_s   = oen_r;
    wen_s   = wen_r;
    case (state_r)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (wb_sel_i == {SW{1'b0}}) begin
            ack_s   = 1'b1;
            state_s = ACK;
          end else begin
            addr_s = wb_adr_i;
            sel_s  = wb_sel_i;
            cen_s  = lane_cen_s;
            ubn_s  = lane_ubn_s;
            lbn_s  = lane_lbn_s;
            if (wb_we_i) begin
              dq_o_s  = wb_dat_i;
              dq_oe_s = wb_sel_i;
              state_s = WR_SETUP;
            end else begin
              oen_s   = 1'b0;
              cnt_s   = CNT_W'(WAIT_RD);
              state_s = RD_ACC;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD_ACC: begin
        if (!wb_cyc_i) begin
          cen_s   = {CHIPS{1'b1}};
          ubn_s   = {CHIPS{1'b1}};
          lbn_s   = {CHIPS{1'b1}};
          oen_s   = 1'b1;
          state_s = TURN;
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          dat_s   = sram_dq_i & byte_mask(sel_r);
          cen_s   = {CHIPS{1'b1}};
          ubn_s   = {CHIPS{1'b1}};
          lbn_s   = {CHIPS{1'b1}};
          oen_s   = 1'b1;
          ack_s   = 1'b1;
          state_s = ACK;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      WR_SETUP, WR_PULSE: begin
        // an abort keeps dq_oe for the TURN cycle so data outlives the WEn edge
        if (!wb_cyc_i) begin
          cen_s   = {CHIPS{1'b1}};
          ubn_s   = {CHIPS{1'b1}};
          lbn_s   = {CHIPS{1'b1}};
          oen_s   = 1'b1;
          wen_s   = 1'b1;
          state_s = TURN;
        end else if (state_r == WR_SETUP) begin
          wen_s   = 1'b0;
          cnt_s   = CNT_W'(WAIT_WR);
          state_s = WR_PULSE;
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          wen_s   = 1'b1;
          cen_s   = {CHIPS{1'b1}};
          ubn_s   = {CHIPS{1'b1}};
          lbn_s   = {CHIPS{1'b1}};
          ack_s   = 1'b1;
          state_s = WR_HOLD;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      WR_HOLD: begin
        dq_oe_s = {SW{1'b0}};
        state_s = TURN;
      end
      TURN: begin
        dq_oe_s = {SW{1'b0}};
        state_s = IDLE;
      end
      ACK: begin
        state_s = IDLE;
      end
      default: begin
        cen_s   = {CHIPS{1'b1}};
        ubn_s   = {CHIPS{1'b1}};
        lbn_s   = {CHIPS{1'b1}};
        oen_s   = 1'b1;
        wen_s   = 1'b1;
        dq_oe_s = {SW{1'b0}};
        state_s = IDLE;
      end
    endcase
  end

  // state, counter and registered pin/bus outputs
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      sel_r   <= {SW{1'b0}};
      ack_r   <= 1'b0;
      dat_r   <= {DW{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      dq_o_r  <= {DW{1'b0}};
      dq_oe_r <= {SW{1'b0}};
      cen_r   <= {CHIPS{1'b1}};
      ubn_r   <= {CHIPS{1'b1}};
      lbn_r   <= {CHIPS{1'b1}};
      oen_r   <= 1'b1;
      wen_r   <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      sel_r   <= sel_s;
      ack_r   <= ack_s;
      dat_r   <= dat_s;
      addr_r  <= addr_s;
      dq_o_r  <= dq_o_s;
      dq_oe_r <= dq_oe_s;
      cen_r   <= cen_s;
      ubn_r   <= ubn_s;
      lbn_r   <= lbn_s;
      oen_r   <= oen_s;
      wen_r   <= wen_s;
    end
  end

  assign wb_ack_o   = ack_r;
  assign wb_dat_o   = dat_r;
  assign sram_addr  = addr_r;
  assign sram_dq_o  = dq_o_r;
  assign sram_dq_oe = dq_oe_r;
  assign sram_cen   = cen_r;
  assign sram_ubn   = ubn_r;
  assign sram_lbn   = lbn_r;
  assign sram_oen   = oen_r;
  assign sram_wen   = wen_r;

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Scoreboard bench for wb_sram_ctrl: directed transfers push expected acks,
// a forked monitor pops and checks them; pin timing is checked per cycle.
module tb_wb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [17:0] adr = 18'd0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] dat_w = 32'd0;
  logic [31:0] dat_r;
  logic        ack;
  logic [17:0] s_addr;
  logic [31:0] s_dq_i, s_dq_o;
  logic [3:0]  s_dq_oe;
  logic [1:0]  s_cen, s_ubn, s_lbn;
  logic        s_oen, s_wen;

  int errors = 0;
  int checks = 0;
  int cycles = 0;

  typedef struct {
    string       name;
    int          cyc;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] mem [0:255];
  logic [31:0] rd_word;

  logic [1:0] h_cen [0:15];
  logic [1:0] h_ubn [0:15];
  logic [1:0] h_lbn [0:15];
  logic [3:0] h_oe  [0:15];
  logic       h_oen [0:15];
  logic       h_wen [0:15];
  logic       h_ack [0:15];

  wb_sram_ctrl #(.ADDR_W(18), .CHIPS(2), .WAIT_RD(1), .WAIT_WR(2)) dut (
    .clk_50mhz (clk),
    .reset     (rst_n),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_adr_i  (adr),
    .wb_sel_i  (sel),
    .wb_dat_i  (dat_w),
    .wb_dat_o  (dat_r),
    .wb_ack_o  (ack),
    .sram_addr (s_addr),
    .sram_dq_i (s_dq_i),
    .sram_dq_o (s_dq_o),
    .sram_dq_oe(s_dq_oe),
    .sram_cen  (s_cen),
    .sram_ubn  (s_ubn),
    .sram_lbn  (s_lbn),
    .sram_oen  (s_oen),
    .sram_wen  (s_wen)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cycles <= cycles + 1;

  // SRAM model: enabled lanes write while WEn is low; disabled lanes read as junk
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!s_cen[b/2] && !s_wen && s_dq_oe[b] &&
          ((b % 2 == 1) ? !s_ubn[b/2] : !s_lbn[b/2]))
        mem[s_addr[7:0]][8*b +: 8] <= s_dq_o[8*b +: 8];
    end
  end

  assign rd_word = (s_addr == 18'h00040) ? 32'h12345678 : mem[s_addr[7:0]];

  always_comb begin
    s_dq_i = 32'hEEEEEEEE;
    for (int b = 0; b < 4; b++) begin
      if (!s_cen[b/2] && !s_oen && ((b % 2 == 1) ? !s_ubn[b/2] : !s_lbn[b/2]))
        s_dq_i[8*b +: 8] = rd_word[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // issue one request, record pins for ncyc cycles, drop stb the cycle after ack
  task automatic xfer(input string nm, input logic w, input logic [17:0] a,
                      input logic [3:0] s, input logic [31:0] d, input int lat,
                      input logic chk_d, input logic [31:0] exp_d,
                      input int ncyc, input int abort_at);
    exp_t e;
    logic acked;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    if (lat >= 0) begin
      e.name = nm; e.cyc = cycles + lat; e.chk_dat = chk_d; e.dat = exp_d;
      sb_q.push_back(e);
    end
    acked = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      if (acked || k == abort_at) begin cyc = 1'b0; stb = 1'b0; end
      @(negedge clk);
      h_cen[k] = s_cen; h_ubn[k] = s_ubn; h_lbn[k] = s_lbn; h_oe[k] = s_dq_oe;
      h_oen[k] = s_oen; h_wen[k] = s_wen; h_ack[k] = ack;
      if (ack) acked = 1'b1;
    end
  endtask

  function automatic int wen_low(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (h_wen[k] == 1'b0) c++;
    return c;
  endfunction

  function automatic int oen_low(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (h_oen[k] == 1'b0) c++;
    return c;
  endfunction

  initial begin
    exp_t e;
    int n_ack;
    logic got;
    fork
      forever begin
        @(negedge clk);
        if (ack === 1'b1) begin
          chk("ack_expected", 64'(sb_q.size() > 0), 64'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.name, "_ack_cycle"}, 64'(cycles), 64'(e.cyc));
            if (e.chk_dat) chk({e.name, "_rdata"}, 64'(dat_r), 64'(e.dat));
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_dat", 64'(dat_r), 64'd0);
    chk("rst_cen_ub_lb", 64'({s_cen, s_ubn, s_lbn}), 64'h3F);
    chk("rst_oen_wen", 64'({s_oen, s_wen}), 64'd3);
    chk("rst_dq", 64'({s_dq_oe, s_dq_o, s_addr}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // full-word write
    xfer("wr_full", 1'b1, 18'h00010, 4'hF, 32'hDEADBEEF, 5, 1'b0, 32'd0, 6, 0);
    chk("wr_full_k1_en", 64'({h_cen[1], h_ubn[1], h_lbn[1]}), 64'd0);
    chk("wr_full_k1_wen_setup", 64'(h_wen[1]), 64'd1);
    chk("wr_full_k1_oe", 64'(h_oe[1]), 64'hF);
    chk("wr_full_wen_low_cycles", 64'(wen_low(6)), 64'd3);
    chk("wr_full_k2_wen", 64'(h_wen[2]), 64'd0);
    chk("wr_full_hold_cen_wen", 64'({h_cen[5], h_wen[5], h_oe[5]}), 64'h7F);
    chk("wr_full_turn_oe", 64'(h_oe[6]), 64'd0);

    // full write then single-byte write into lane 2
    xfer("wr_base", 1'b1, 18'h00011, 4'hF, 32'h11223344, 5, 1'b0, 32'd0, 6, 0);
    xfer("wr_byte", 1'b1, 18'h00011, 4'b0100, 32'h00AA0000, 5, 1'b0, 32'd0, 6, 0);
    chk("wr_byte_cen", 64'(h_cen[1]), 64'b01);
    chk("wr_byte_ubn", 64'(h_ubn[1]), 64'b11);
    chk("wr_byte_lbn", 64'(h_lbn[1]), 64'b01);
    chk("wr_byte_oe", 64'(h_oe[1]), 64'b0100);
    xfer("rd_byte", 1'b0, 18'h00011, 4'hF, 32'd0, 3, 1'b1, 32'h11AA3344, 4, 0);

    // partial read with wait state
    xfer("rd_part", 1'b0, 18'h00040, 4'b0011, 32'd0, 3, 1'b1, 32'h00005678, 4, 0);
    chk("rd_part_oen_low", 64'(oen_low(4)), 64'd2);
    chk("rd_part_cen", 64'(h_cen[1]), 64'b10);

    // write followed by read with stb held across TURN
    xfer("b2b_wr", 1'b1, 18'h00020, 4'hF, 32'hCAFEF00D, 5, 1'b0, 32'd0, 5, 0);
    @(posedge clk); #1;
    we = 1'b0;
    e.name = "b2b_rd"; e.cyc = cycles + 4; e.chk_dat = 1'b1; e.dat = 32'hCAFEF00D;
    sb_q.push_back(e);
    @(negedge clk);
    chk("b2b_turn_gap", 64'({s_dq_oe, s_oen, s_wen}), 64'b000011);
    @(posedge clk); #1; @(negedge clk);
    chk("b2b_idle_gap", 64'({s_dq_oe, s_oen}), 64'b00001);
    @(posedge clk); #1; @(negedge clk);
    chk("b2b_rd_oen", 64'({s_dq_oe, s_oen}), 64'b00000);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1; @(negedge clk);
      if (ack) got = 1'b1;
    end
    chk("b2b_ack_seen", 64'(got), 64'd1);
    @(posedge clk); #1; cyc = 1'b0; stb = 1'b0;

    // abort during write pulse
    xfer("abort", 1'b1, 18'h00030, 4'hF, 32'h55555555, -1, 1'b0, 32'd0, 6, 3);
    chk("abort_pulse_wen", 64'(h_wen[3]), 64'd0);
    chk("abort_release", 64'({h_wen[4], h_oen[4], h_cen[4]}), 64'b1111);
    chk("abort_oe_held", 64'(h_oe[4]), 64'hF);
    chk("abort_oe_drop", 64'(h_oe[5]), 64'd0);
    n_ack = 0;
    for (int k = 1; k <= 6; k++) if (h_ack[k]) n_ack++;
    chk("abort_no_ack", 64'(n_ack), 64'd0);
    xfer("rd_after_abort", 1'b0, 18'h00040, 4'hF, 32'd0, 3, 1'b1, 32'h12345678, 4, 0);

    // empty byte select
    xfer("sel0", 1'b1, 18'h00050, 4'h0, 32'hFFFFFFFF, 1, 1'b0, 32'd0, 3, 0);
    got = 1'b0;
    for (int k = 1; k <= 3; k++)
      if (h_cen[k] != 2'b11 || !h_oen[k] || !h_wen[k] || h_oe[k] != 4'd0) got = 1'b1;
    chk("sel0_no_pins", 64'(got), 64'd0);

    // reset during read access
    xfer("rd_rst", 1'b0, 18'h00010, 4'hF, 32'd0, -1, 1'b0, 32'd0, 1, 0);
    chk("rd_rst_in_access", 64'(h_oen[1]), 64'd0);
    #2; rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
    #1;
    chk("rst_mid_pins", 64'({s_cen, s_ubn, s_lbn, s_oen, s_wen}), 64'hFF);
    chk("rst_mid_ack_addr", 64'({ack, s_addr, s_dq_oe}), 64'd0);
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    xfer("rd_post_rst", 1'b0, 18'h00010, 4'hF, 32'd0, 3, 1'b1, 32'hDEADBEEF, 4, 0);
    chk("rd_post_rst_oen_low", 64'(oen_low(4)), 64'd2);

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
